bcd_to_bin: RTL
===============

Name: bcd_to_bin

Overview:
- Sequential converter from a packed multi-digit BCD value to plain unsigned binary.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any BCD digit that is >= 8.
- Sits downstream of the BCD counters and display-side logic, so BCD counts can feed binary arithmetic and compare logic.
- Valid/ready on the input side; output is held until accepted.

Parameters:
- DIGITS, 4, number of BCD digits in the input.
- BIN_W, 14, binary result width. Must be >= ceil(log2(10^DIGITS)). Tie to 14 when DIGITS=4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  bcd_in is valid this cycle.
- in_ready  output  1  converter idle; can accept a value.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is bcd_in[3:0].
- out_valid  output  1  bin_out (and err) hold a result.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_W  binary result.
- err  output  1  at least one input digit was > 9 (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; bin_out=0, err=0, out_valid=0.
  - shift counter and work register are cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-conversion or mid-DONE abandons the result; no out_valid is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at edge k: load the work register as {bcd_in, BIN_W'b0}, clear the counter, go to SHIFT.
- SHIFT (in_ready=0):
  - Each edge shifts the whole work register right by 1; the LSB of the BCD field enters the binary field MSB.
  - In the same cycle, each post-shift BCD digit d becomes d-3 if d >= 8, else d unchanged.
  - After BIN_W shifts (edges k+1 .. k+BIN_W), go to DONE.
  - At that point bin_out is the binary field and the BCD field is all zero.
- DONE:
  - out_valid=1 from edge k+BIN_W. Latency from accept to out_valid is exactly BIN_W cycles (14 by default).
  - bin_out and err hold stable while out_valid && !out_ready, for any number of cycles.
  - On out_valid && out_ready, go to IDLE; in_ready=1 the next cycle.
  - No input/output overlap: throughput is one conversion per BIN_W+2 cycles minimum.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Width rules:
  - Digit adjustment is 4-bit unsigned; it never underflows, because adjustment applies only to d >= 8.
  - The shift counter is $clog2(BIN_W+1) bits.
- Boundary values:
  - all-zero input gives 0.
  - all-nines input gives 10^DIGITS - 1 (9999 = 0x270F for DIGITS=4).

Optional Feature:
- Macro: BCD2BIN_ERR_CHECK_EN.
- Defined:
  - At accept, every digit of bcd_in is compared against 9; err latches 1 if any digit is > 9.
  - The conversion still runs the full BIN_W cycles. err is presented with out_valid, and bin_out is forced to 0 when err=1.
  - err clears on the next accept or on reset.
- Undefined:
  - No digit check; err is tied to 0.
  - Invalid digits convert through the same algorithm, and bin_out is unspecified but deterministic.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=4'd9, ADJ_THRESH=4'd8, ADJ_SUB=4'd3.
  - State typedef bcd2bin_state_t {IDLE, SHIFT, DONE}.
  - These are reused by the BCD counters and future bin_to_bcd.
- Sub-module bcd_digit_adj: purely combinational, one 4-bit digit in, adjusted digit out. Instantiated DIGITS times via generate.

Test Plan:
- Reset then bcd_in=16'h0000, in_valid=1 -> in_ready drops; after 14 cycles out_valid=1, bin_out=0, err=0.
- bcd_in=16'h9999 -> bin_out=14'h270F (9999) exactly 14 cycles after accept; bcd_in=16'h1234 -> bin_out=14'h04D2.
- Backpressure: hold out_ready=0 for 20 cycles after 16'h0505 -> bin_out=505 stable, out_valid stays 1, in_ready=0; in_valid pulses during this time are ignored. Release -> in_ready=1 the next cycle.
- With BCD2BIN_ERR_CHECK_EN, bcd_in=16'h12A4 -> err=1, bin_out=0 with out_valid. The following 16'h0042 -> err=0, bin_out=42.
- rst=1 at the 7th SHIFT cycle of 16'h8765 -> next cycle out_valid=0, bin_out=0, in_ready=1; no stale result appears. A new 16'h0010 converts to 10.
- Random sweep of 0..9999 back-to-back at maximum rate -> bin_out matches the decimal value for every input; one result per accept, in order.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: constants and state type shared by the BCD counters and converters.
`default_nettype none

package bcd_pkg;

    localparam int        BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd2bin_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction (subtract 3 when d >= 8).
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Only applied to d >= 8, so the 4-bit subtraction cannot wrap.
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to binary converter, one shift per cycle.
// Optional digit-range check enabled by macro BCD2BIN_ERR_CHECK_EN.
`default_nettype none

module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          err
);

    localparam int c_BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int c_WORK_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W  = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    bcd2bin_state_t        r_state;
    logic [c_WORK_W-1:0]   r_work;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]      r_bin;
    logic                  r_err;
    logic                  r_err_pend;
    logic                  r_out_valid;
    logic                  r_in_ready;

    logic [c_WORK_W-1:0]   w_shift;
    logic [c_WORK_W-1:0]   w_next;
    logic                  w_in_err;

    assign w_shift              = r_work >> 1;
    assign w_next[BIN_W-1:0]    = w_shift[BIN_W-1:0];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (w_shift[BIN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_next [BIN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD2BIN_ERR_CHECK_EN
    logic [DIGITS-1:0] w_bad;

    generate
        for (genvar j = 0; j < DIGITS; j++) begin : g_chk
            assign w_bad[j] = (bcd_in[j*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX);
        end
    endgenerate

    assign w_in_err = |w_bad;
`else
    assign w_in_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_err       <= 1'b0;
            r_err_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= {bcd_in, {BIN_W{1'b0}}};
                        r_cnt      <= '0;
                        r_err_pend <= w_in_err;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    // Final shift: result is captured from the post-shift binary field.
                    if (r_cnt == c_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_err       <= r_err_pend;
                        r_bin       <= r_err_pend ? '0 : w_next[BIN_W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin;
    assign err       = r_err;

endmodule

`default_nettype wire
